// File: rtl/complex_addsub.sv
// rtl/complex_addsub.sv - pipelined binary64 complex add/subtract with valid/ready output register
// One combinational FP add lane per component, results captured in a single output stage.

module complex_addsub_lane (
    input  logic [63:0] i_x,
    input  logic [63:0] i_y,
    input  logic        i_sub,
    output logic [63:0] o_sum
);
    localparam logic [63:0] QNAN = 64'h7FF8_0000_0000_0000;

    logic               w_sx, w_sy, w_sl;
    logic [10:0]        w_ex, w_ey, w_el, w_es, w_dexp;
    logic [51:0]        w_fx, w_fy;
    logic               w_nan_x, w_nan_y, w_inf_x, w_inf_y, w_zero_x, w_zero_y;
    logic               w_swap, w_eff_sub;
    logic [52:0]        w_ml, w_ms;
    logic [55:0]        w_big, w_small, w_diff, w_norm;
    logic [111:0]       w_shift_full;
    logic [56:0]        w_add;
    logic [5:0]         w_lz;
    logic signed [12:0] w_exp_n, w_exp_r;
    logic               w_rnd_up;
    logic [53:0]        w_mant_r;

    assign w_sx = i_x[63];
    assign w_sy = i_y[63] ^ i_sub;
    assign w_ex = i_x[62:52];
    assign w_ey = i_y[62:52];
    assign w_fx = i_x[51:0];
    assign w_fy = i_y[51:0];

    assign w_nan_x  = (w_ex == 11'h7FF) && (w_fx != 52'd0);
    assign w_nan_y  = (w_ey == 11'h7FF) && (w_fy != 52'd0);
    assign w_inf_x  = (w_ex == 11'h7FF) && (w_fx == 52'd0);
    assign w_inf_y  = (w_ey == 11'h7FF) && (w_fy == 52'd0);
    // Subnormal inputs collapse to signed zero here.
    assign w_zero_x = (w_ex == 11'd0);
    assign w_zero_y = (w_ey == 11'd0);

    assign w_swap    = {w_ey, w_fy} > {w_ex, w_fx};
    assign w_eff_sub = w_sx ^ w_sy;
    assign w_sl      = w_swap ? w_sy : w_sx;
    assign w_el      = w_swap ? w_ey : w_ex;
    assign w_es      = w_swap ? w_ex : w_ey;
    assign w_ml      = {1'b1, (w_swap ? w_fy : w_fx)};
    assign w_ms      = {1'b1, (w_swap ? w_fx : w_fy)};
    assign w_dexp    = w_el - w_es;

    // Significands carry guard/round/sticky in the three low bits.
    assign w_big        = {w_ml, 3'b000};
    assign w_shift_full = {w_ms, 3'b000, 56'd0} >> w_dexp;
    assign w_small      = (w_dexp > 11'd55) ? 56'd1
                        : {w_shift_full[111:57], w_shift_full[56] | (|w_shift_full[55:0])};

    assign w_add  = {1'b0, w_big} + {1'b0, w_small};
    assign w_diff = w_big - w_small;

    always_comb begin
        w_lz = 6'd0;
        for (int k = 0; k < 56; k++) begin
            if (w_diff[k]) w_lz = 6'(55 - k);
        end
    end

    always_comb begin
        w_norm  = w_add[55:0];
        w_exp_n = {2'b00, w_el};
        if (w_eff_sub) begin
            w_norm  = w_diff << w_lz;
            w_exp_n = {2'b00, w_el} - {7'd0, w_lz};
        end else if (w_add[56]) begin
            w_norm  = {w_add[56:2], w_add[1] | w_add[0]};
            w_exp_n = {2'b00, w_el} + 13'sd1;
        end
    end

    assign w_rnd_up = w_norm[2] & (w_norm[1] | w_norm[0] | w_norm[3]);
    assign w_mant_r = {1'b0, w_norm[55:3]} + {53'd0, w_rnd_up};
    assign w_exp_r  = w_exp_n + {12'd0, w_mant_r[53]};

    always_comb begin
        o_sum = {w_sl, w_exp_r[10:0], w_mant_r[51:0]};
        if (w_nan_x || w_nan_y || (w_inf_x && w_inf_y && w_eff_sub))
            o_sum = QNAN;
        else if (w_inf_x)
            o_sum = {w_sx, 11'h7FF, 52'd0};
        else if (w_inf_y)
            o_sum = {w_sy, 11'h7FF, 52'd0};
        else if (w_zero_x && w_zero_y)
            o_sum = {w_sx & w_sy, 63'd0};
        else if (w_zero_x)
            o_sum = {w_sy, i_y[62:0]};
        else if (w_zero_y)
            o_sum = i_x;
        else if (w_eff_sub && (w_diff == 56'd0))
            o_sum = 64'd0;
        else if (w_exp_r >= 13'sd2047)
            o_sum = {w_sl, 11'h7FF, 52'd0};
        else if (w_exp_r <= 13'sd0)
            o_sum = {w_sl, 63'd0};
    end
endmodule

module complex_addsub #(
    parameter int WIDTH        = 64,
    parameter int NUM_OPERANDS = 4
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic [NUM_OPERANDS-1:0][WIDTH-1:0] operands_i,
    input  logic                               sub,
    input  logic                               in_valid_i,
    output logic                               in_ready_o,
    input  logic                               flush_i,
    output logic [1:0][WIDTH-1:0]              result_o,
    output logic                               out_valid_o,
    input  logic                               out_ready_i,
    output logic                               busy_o
);
    logic [WIDTH-1:0]     w_re, w_im;
    logic                 w_accept;
    logic [1:0][WIDTH-1:0] r_result;
    logic                 r_valid;

    complex_addsub_lane u_re (
        .i_x   (operands_i[0]),
        .i_y   (operands_i[2]),
        .i_sub (sub),
        .o_sum (w_re)
    );

    complex_addsub_lane u_im (
        .i_x   (operands_i[1]),
        .i_y   (operands_i[3]),
        .i_sub (sub),
        .o_sum (w_im)
    );

    assign in_ready_o = ~r_valid | out_ready_i;
    assign w_accept   = in_valid_i & in_ready_o;

    // Flush has priority over a same-cycle accept.
    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            r_valid  <= 1'b0;
            r_result <= '0;
        end else if (w_accept) begin
            r_valid  <= 1'b1;
            r_result <= {w_im, w_re};
        end else if (out_ready_i) begin
            r_valid  <= 1'b0;
        end
    end

    assign result_o    = r_result;
    assign out_valid_o = r_valid;
    assign busy_o      = r_valid;
endmodule

// File: tb/tb_complex_addsub.sv
// tb/tb_complex_addsub.sv - self-checking bench for complex_addsub
// Reference arithmetic uses native double-precision real addition plus the zero/NaN rules.

module tb_complex_addsub;
    localparam logic [63:0] QNAN = 64'h7FF8_0000_0000_0000;

    logic             clk_i = 1'b0;
    logic             rst_i = 1'b1;
    logic [3:0][63:0] operands = '0;
    logic             sub_s = 1'b0;
    logic             in_valid_i = 1'b0;
    logic             in_ready_o;
    logic             flush_i = 1'b0;
    logic [1:0][63:0] result;
    logic             out_valid_o;
    logic             out_ready_i = 1'b0;
    logic             busy_o;

    int n_total = 0;
    int n_bad   = 0;

    logic        m_valid = 1'b0;
    logic [63:0] m_re = '0;
    logic [63:0] m_im = '0;

    complex_addsub #(.WIDTH(64), .NUM_OPERANDS(4)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .operands_i  (operands),
        .sub         (sub_s),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .flush_i     (flush_i),
        .result_o    (result),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .busy_o      (busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] ref_add(input logic [63:0] x, input logic [63:0] y, input logic s);
        logic [63:0] xx, yy, z;
        real         rz;
        xx = x;
        yy = {y[63] ^ s, y[62:0]};
        if (xx[62:52] == 11'd0) xx = {xx[63], 63'd0};
        if (yy[62:52] == 11'd0) yy = {yy[63], 63'd0};
        rz = $bitstoreal(xx) + $bitstoreal(yy);
        z  = $realtobits(rz);
        if (z[62:52] == 11'h7FF && z[51:0] != 52'd0) return QNAN;
        if (z[62:52] == 11'd0) return {z[63], 63'd0};
        return z;
    endfunction

    task automatic drive(input logic [63:0] a1, input logic [63:0] b1, input logic [63:0] a2,
                         input logic [63:0] b2, input logic s, input logic v, input logic rdy);
        operands    = {b2, a2, b1, a1};
        sub_s       = s;
        in_valid_i  = v;
        out_ready_i = rdy;
    endtask

    task automatic tick();
        logic acc;
        acc = in_valid_i && (!m_valid || out_ready_i);
        if (rst_i || flush_i) begin
            m_valid = 1'b0;
            m_re    = '0;
            m_im    = '0;
        end else if (acc) begin
            m_valid = 1'b1;
            m_re    = ref_add(operands[0], operands[2], sub_s);
            m_im    = ref_add(operands[1], operands[3], sub_s);
        end else if (out_ready_i) begin
            m_valid = 1'b0;
        end
        @(posedge clk_i);
        #1;
        check("out_valid", {63'd0, out_valid_o}, {63'd0, m_valid});
        check("busy", {63'd0, busy_o}, {63'd0, m_valid});
        check("in_ready", {63'd0, in_ready_o}, {63'd0, (!m_valid || out_ready_i)});
        if (m_valid) begin
            check("res_re", result[0], m_re);
            check("res_im", result[1], m_im);
        end
    endtask

    function automatic logic [63:0] rand_op();
        logic [63:0] v;
        int          k;
        v = {$urandom, $urandom};
        k = $urandom_range(0, 9);
        case (k)
            0:       v[62:52] = 11'd0;
            1:       begin v[62:52] = 11'h7FF; if ($urandom_range(0, 1) == 0) v[51:0] = '0; end
            2, 3, 4: v[62:52] = 11'($urandom_range(1015, 1030));
            5:       v[62:52] = 11'($urandom_range(2040, 2046));
            6:       v[62:52] = 11'($urandom_range(1, 8));
            default: ;
        endcase
        return v;
    endfunction

    initial begin
        logic [63:0] x0, x1, y0, y1;

        repeat (2) tick();
        check("rst_re", result[0], 64'd0);
        check("rst_im", result[1], 64'd0);
        rst_i = 1'b0;
        tick();

        drive(64'h3FF8000000000000, 64'h4000000000000000, 64'h3FE0000000000000, 64'hBFF0000000000000, 1'b1, 1'b1, 1'b1);
        tick();
        check("tp_sub_re", result[0], 64'h3FF0000000000000);
        check("tp_sub_im", result[1], 64'h4008000000000000);

        drive(64'h3FF0000000000000, 64'h3FF0000000000000, 64'h4000000000000000, 64'hC008000000000000, 1'b0, 1'b1, 1'b1);
        tick();
        check("tp_add_re", result[0], 64'h4008000000000000);
        check("tp_add_im", result[1], 64'hC000000000000000);

        drive(64'h4015000000000000, 64'h3FF0000000000000, 64'h4015000000000000, 64'h3CA0000000000000, 1'b0, 1'b1, 1'b1);
        sub_s = 1'b1;
        tick();
        check("cancel", result[0], 64'h0000000000000000);
        drive(64'h3FF0000000000000, 64'h3FF0000000000000, 64'h3CA0000000000000, 64'h3CB0000000000000, 1'b0, 1'b1, 1'b1);
        tick();
        check("tie_even", result[0], 64'h3FF0000000000000);
        check("ulp_up", result[1], 64'h3FF0000000000001);
        drive(64'h7FEFFFFFFFFFFFFF, 64'h8000000000000000, 64'h7FEFFFFFFFFFFFFF, 64'h8000000000000000, 1'b0, 1'b1, 1'b1);
        tick();
        check("overflow", result[0], 64'h7FF0000000000000);
        check("neg_zero", result[1], 64'h8000000000000000);

        drive(64'h7FF0000000000000, 64'h4000000000000000, 64'h7FF0000000000000, 64'h3FF0000000000000, 1'b1, 1'b1, 1'b1);
        tick();
        check("inf_inf", result[0], QNAN);
        check("inf_lane_im", result[1], 64'h3FF0000000000000);
        drive(64'h7FF0000000000001, 64'h4000000000000000, 64'h3FF0000000000000, 64'h3FF0000000000000, 1'b0, 1'b1, 1'b1);
        tick();
        check("nan_in", result[0], QNAN);
        check("nan_lane_im", result[1], 64'h4008000000000000);

        drive(64'h3FF8000000000000, 64'h4000000000000000, 64'h3FE0000000000000, 64'hBFF0000000000000, 1'b1, 1'b1, 1'b1);
        tick();
        drive(64'h4000000000000000, 64'h4000000000000000, 64'h4000000000000000, 64'h4000000000000000, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_ready", {63'd0, in_ready_o}, 64'd0);
            check("bp_hold_re", result[0], 64'h3FF0000000000000);
        end
        drive(64'h3FF0000000000000, 64'h3FF0000000000000, 64'h4000000000000000, 64'hC008000000000000, 1'b0, 1'b1, 1'b1);
        tick();
        check("bp_new_valid", {63'd0, out_valid_o}, 64'd1);
        check("bp_new_re", result[0], 64'h4008000000000000);

        for (int pass = 0; pass < 2; pass++) begin
            drive(64'h3FF8000000000000, 64'h4000000000000000, 64'h3FE0000000000000, 64'hBFF0000000000000, 1'b1, 1'b1, 1'b1);
            tick();
            in_valid_i  = 1'b0;
            out_ready_i = 1'b0;
            tick();
            in_valid_i = 1'b1;
            if (pass == 0) flush_i = 1'b1; else rst_i = 1'b1;
            tick();
            check("clr_valid", {63'd0, out_valid_o}, 64'd0);
            check("clr_busy", {63'd0, busy_o}, 64'd0);
            check("clr_re", result[0], 64'd0);
            check("clr_im", result[1], 64'd0);
            flush_i = 1'b0;
            rst_i   = 1'b0;
            drive(64'h3FF0000000000000, 64'h3FF0000000000000, 64'h4000000000000000, 64'hC008000000000000, 1'b0, 1'b1, 1'b1);
            tick();
            check("post_clr_re", result[0], 64'h4008000000000000);
            check("post_clr_im", result[1], 64'hC000000000000000);
        end

        for (int n = 0; n < 3000; n++) begin
            x0 = rand_op();
            x1 = rand_op();
            y0 = rand_op();
            y1 = rand_op();
            if ($urandom_range(0, 7) == 0) y0 = x0 ^ {56'd0, 8'($urandom_range(0, 255))};
            if ($urandom_range(0, 7) == 0) y1 = {~x1[63], x1[62:0]};
            drive(x0, x1, y0, y1, 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0));
            flush_i = ($urandom_range(0, 63) == 0);
            tick();
        end
        flush_i = 1'b0;

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule

// File: doc/complex_addsub.md
Name: complex_addsub

Overview:
- Pipelined complex adder/subtractor on IEEE-754 double-precision (binary64) operands.
- Computes x + y or x - y for x = a1 + j·b1 and y = a2 + j·b2, using two independent FP add lanes (real, imaginary).
- Serves as the accumulate/subtract step after the complex matrix-multiply unit, e.g. the Schur-complement update A - L·U in the blocked LU flow.
- Uses the codebase valid/ready + flush + busy handshake.

Parameters:
- WIDTH, 64, operand width; only 64 (binary64) is supported.
- NUM_OPERANDS, 4, number of packed scalar operands {b2,a2,b1,a1}; fixed at 4.

Ports:
- clk_i  in  1  clock; all logic on the rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- operands_i  in  4x64  [0]=a1 re x, [1]=b1 im x, [2]=a2 re y, [3]=b2 im y.
- sub  in  1  0: x+y; 1: x-y. Sampled together with the operands.
- in_valid_i  in  1  input valid.
- in_ready_o  out  1  input can be accepted.
- flush_i  in  1  discard pipeline contents.
- result_o  out  2x64  [0]=real, [1]=imag.
- out_valid_o  out  1  result_o valid.
- out_ready_i  in  1  downstream accepts result.
- busy_o  out  1  operation in flight.

Behaviour:
- Pipeline: single output register stage; latency 1 cycle from an accepted input to out_valid_o.
- Accept condition: in_valid_i & in_ready_o at a clock edge.
- in_ready_o = ~out_valid_o | out_ready_i (combinational).
- On accept: result register loads the computed value and out_valid_o <= 1.
- Output handshake: out_valid_o & out_ready_i with no new accept clears out_valid_o. Simultaneous accept and drain keeps out_valid_o = 1 and loads the new result.
- Back-pressure: while out_valid_o = 1 and out_ready_i = 0, result_o holds stable and in_ready_o = 0.
- busy_o = out_valid_o.
- Reset (rst_i = 1 at an edge): out_valid_o = 0, result_o = 0, busy_o = 0. Any in-flight result is dropped, including on reset mid-operation.
- flush_i = 1 at an edge: out_valid_o <= 0 and result_o <= 0. A simultaneous accept is ignored; flush wins.
- Arithmetic per lane (re: a1 ± a2; im: b1 ± b2): sub inverts the sign bit of y in both lanes before a true signed addition.
- Rounding: round-to-nearest-even using guard, round and sticky bits, with full 53-bit significand alignment.
- Subnormal inputs are treated as signed zero. Subnormal results are flushed to zero, keeping the sign.
- Overflow produces ±Inf with the correct sign.
- Exact-zero result is +0, except (-0)+(-0) (after the sub inversion) = -0.
- Any NaN input produces canonical qNaN 0x7FF8000000000000.
- (+Inf)+(-Inf), after the sub inversion, produces canonical qNaN. Inf ± finite = that Inf.
- The two lanes are fully independent. A special value in one lane does not affect the other.
- Inputs other than operands/sub/in_valid are don't-care when no accept occurs.

Test Plan:
- Subtract: sub=1; a1=1.5 (0x3FF8000000000000), b1=2.0, a2=0.5, b2=-1.0; accept -> next cycle out_valid_o=1, result_o[0]=0x3FF0000000000000 (1.0), result_o[1]=0x4008000000000000 (3.0).
- Add: sub=0; x=1.0+j1.0, y=2.0-j3.0 -> real 0x4008000000000000 (3.0), imag 0xC000000000000000 (-2.0).
- Cancellation/rounding: sub=1, 5.25-5.25 -> 0x0000000000000000. sub=0, 1.0 + 2^-53 -> 0x3FF0000000000000 (tie to even). 1.0 + 2^-52 -> 0x3FF0000000000001. 0x7FEFFFFFFFFFFFFF + same -> 0x7FF0000000000000.
- Specials: sub=1, re +Inf - +Inf -> 0x7FF8000000000000, while im 2.0-1.0 = 0x3FF0000000000000 in the same transfer. Re NaN input -> 0x7FF8000000000000.
- Back-pressure: out_ready_i=0 after one accept -> in_ready_o=0, result_o stable for 5 cycles. Raise out_ready_i with a new valid input -> new result appears next cycle, out_valid_o stays 1.
- Reset/flush: result pending with out_ready_i=0; assert flush_i for one cycle -> out_valid_o=0, busy_o=0, result_o=0. Repeat with rst_i -> same. The first accept after release produces a correct result 1 cycle later.
